// File: rtl/data_rom_load_ctrl_pkg.sv
// data_rom_load_ctrl_pkg: shared load encodings, fault codes, FSM states and ROM defaults
package data_rom_load_ctrl_pkg;
    localparam logic [1:0] XLEN_32b = 2'd1;
    localparam logic [1:0] XLEN_64b = 2'd2;
    localparam logic [63:0] ROM_DATA_LO = 64'h1000;
    localparam logic [63:0] ROM_DATA_HI = 64'h1FFF;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;
    localparam logic [1:0] FLT_OK       = 2'b00;
    localparam logic [1:0] FLT_RANGE    = 2'b01;
    localparam logic [1:0] FLT_MISALIGN = 2'b10;
    localparam logic [1:0] FLT_ILLEGAL  = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
    function automatic logic [3:0] load_size(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction
endpackage

// File: rtl/data_rom_load_ctrl_load_extend.sv
// load_extend: selects the low 1/2/4/8 bytes of a ROM word and sign- or zero-extends them
module load_extend
    import data_rom_load_ctrl_pkg::*;
#(
    parameter logic [1:0] XLEN = XLEN_64b,
    localparam int W = 1 << (XLEN + 4)
) (
    input  logic [W-1:0] raw,
    input  logic [2:0]   funct3,
    output logic [W-1:0] ext
);
    logic [6:0]   bits;
    logic [W-1:0] keep;
    logic         sign;
    always_comb begin
        bits = 7'd8 << funct3[1:0];
        keep = ~({W{1'b1}} << bits);
        sign = ~funct3[2] & |(raw & (keep ^ (keep >> 1)));
        ext  = (raw & keep) | (sign ? ~keep : '0);
    end
endmodule

// File: rtl/data_rom_load_ctrl.sv
// data_rom_load_ctrl: round-robin two-port load controller for the read-only data ROM
module data_rom_load_ctrl
    import data_rom_load_ctrl_pkg::*;
#(
    parameter logic [1:0]  XLEN   = XLEN_64b,
    parameter logic [63:0] ROM_LO = ROM_DATA_LO,
    parameter logic [63:0] ROM_HI = ROM_DATA_HI,
    localparam int W = 1 << (XLEN + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [1:0]   i_req_valid,
    output logic [1:0]   o_req_ready,
    input  logic [W-1:0] i_req_addr0,
    input  logic [W-1:0] i_req_addr1,
    input  logic [2:0]   i_req_funct3_0,
    input  logic [2:0]   i_req_funct3_1,
    output logic [W-1:0] o_rom_addr,
    input  logic [W-1:0] i_rom_data,
    output logic [1:0]   o_rsp_valid,
    output logic [W-1:0] o_rsp_data,
    output logic [1:0]   o_rsp_fault
);
    localparam logic [W:0] LO = {1'b0, ROM_LO[W-1:0]};
    localparam logic [W:0] HI = {1'b0, ROM_HI[W-1:0]};
    state_t       state, state_nx;
    logic         last_grant, port, hs;
    logic [W-1:0] addr, rom_addr_q, ext;
    logic [2:0]   f3;
    logic [1:0]   gnt, fault;
    logic [3:0]   size;
    logic [W:0]   last_byte;
    logic         illegal, misaligned, out_of_range;
    load_extend #(.XLEN(XLEN)) u_ext (.raw(i_rom_data), .funct3(f3), .ext(ext));
    always_comb begin
        gnt          = &i_req_valid ? (last_grant ? 2'b01 : 2'b10) : i_req_valid;
        o_req_ready  = (state == ST_IDLE && !i_rst) ? gnt : 2'b00;
        hs           = |(i_req_valid & o_req_ready);
        size         = load_size(f3);
        last_byte    = {1'b0, addr} + {{(W-3){1'b0}}, size - 4'd1};
        illegal      = f3 == F3_BAD || (XLEN == XLEN_32b && (f3 == F3_LD || f3 == F3_LWU));
        misaligned   = |(addr[2:0] & (size[2:0] - 3'd1));
        out_of_range = {1'b0, addr} < LO || last_byte > HI;
        fault        = illegal ? FLT_ILLEGAL : misaligned ? FLT_MISALIGN : out_of_range ? FLT_RANGE : FLT_OK;
        o_rom_addr   = state != ST_ACCESS ? rom_addr_q : fault == FLT_OK ? addr - ROM_LO[W-1:0] : '0;
        o_rsp_valid  = state == ST_RESP ? (port ? 2'b10 : 2'b01) : 2'b00;
        state_nx     = state == ST_IDLE ? (hs ? ST_ACCESS : ST_IDLE) : state == ST_ACCESS ? ST_RESP : ST_IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            port        <= 1'b0;
            addr        <= '0;
            f3          <= '0;
            rom_addr_q  <= '0;
            o_rsp_data  <= '0;
            o_rsp_fault <= FLT_OK;
        end else begin
            state <= state_nx;
            if (hs) begin
                port       <= gnt[1];
                last_grant <= gnt[1];
                addr       <= gnt[1] ? i_req_addr1 : i_req_addr0;
                f3         <= gnt[1] ? i_req_funct3_1 : i_req_funct3_0;
            end
            if (state == ST_ACCESS) begin
                rom_addr_q  <= o_rom_addr;
                o_rsp_data  <= fault == FLT_OK ? ext : '0;
                o_rsp_fault <= fault;
            end
        end
    end
endmodule

// File: tb/tb_data_rom_load_ctrl.sv
// tb_data_rom_load_ctrl: scoreboard bench for 64-bit and 32-bit instances of the ROM load controller
module tb_data_rom_load_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  v64 = 2'b00, v32 = 2'b00;
    logic [63:0] a0 = '0, a1 = '0;
    logic [2:0]  f0 = '0, f1 = '0;
    logic [1:0]  rdy64, rdy32, rv64, rv32, rf64, rf32;
    logic [63:0] ra64, rq64, rd64;
    logic [31:0] ra32, rq32, rd32;
    logic [7:0]  rom [256];
    int          checks = 0, failures = 0, cyc = 0;
    typedef struct {
        bit          d;
        int          p;
        logic [63:0] data;
        logic [1:0]  fault;
        string       nm;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    data_rom_load_ctrl #(.XLEN(2'd2), .ROM_LO(64'h1000), .ROM_HI(64'h10FD)) u64 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(v64), .o_req_ready(rdy64),
        .i_req_addr0(a0), .i_req_addr1(a1), .i_req_funct3_0(f0), .i_req_funct3_1(f1),
        .o_rom_addr(ra64), .i_rom_data(rq64), .o_rsp_valid(rv64), .o_rsp_data(rd64), .o_rsp_fault(rf64));

    data_rom_load_ctrl #(.XLEN(2'd1), .ROM_LO(64'h1000), .ROM_HI(64'h10FD)) u32 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(v32), .o_req_ready(rdy32),
        .i_req_addr0(a0[31:0]), .i_req_addr1(a1[31:0]), .i_req_funct3_0(f0), .i_req_funct3_1(f1),
        .o_rom_addr(ra32), .i_rom_data(rq32), .o_rsp_valid(rv32), .o_rsp_data(rd32), .o_rsp_fault(rf32));

    always_comb begin
        for (int i = 0; i < 8; i++) rq64[8*i +: 8] = rom[8'(ra64 + 64'(i))];
        for (int i = 0; i < 4; i++) rq32[8*i +: 8] = rom[8'(ra32 + 32'(i))];
    end

    // Scoreboard: every response strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (|rv64 || |rv32) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected rsp64=%b rsp32=%b", rv64, rv32);
            end else begin
                e = sb.pop_front();
                if ((e.d ? rv32 : rv64) !== (2'b01 << e.p) || (e.d ? {32'b0, rd32} : rd64) !== e.data ||
                    (e.d ? rf32 : rf64) !== e.fault) begin
                    failures++;
                    $display("FAIL %s got valid=%b data=%h fault=%b, expected valid=%b data=%h fault=%b",
                             e.nm, e.d ? rv32 : rv64, e.d ? {32'b0, rd32} : rd64, e.d ? rf32 : rf64,
                             2'b01 << e.p, e.data, e.fault);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic do_load(input bit d, input int p, input logic [63:0] a, input logic [2:0] f,
                           input logic [63:0] ed, input logic [1:0] ef, input string nm);
        logic [63:0] exp_ra, ra;
        logic [1:0]  rv;
        bit          got;
        exp_ra = ef == 2'b00 ? a - 64'h1000 : 64'h0;
        sb.push_back('{d, p, ed, ef, nm});
        if (p == 0) begin a0 = a; f0 = f; end else begin a1 = a; f1 = f; end
        if (d) v32[p] = 1'b1; else v64[p] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = d ? rdy32[p] : rdy64[p];
        end
        checks++;
        if (!got) begin failures++; $display("FAIL %s_ready timeout got=0 expected=1", nm); end
        @(posedge clk); #1;
        v64 = 2'b00; v32 = 2'b00;
        @(negedge clk);
        rv = d ? rv32 : rv64; ra = d ? {32'b0, ra32} : ra64;
        checks++;
        if (rv !== 2'b00 || ra !== exp_ra) begin
            failures++;
            $display("FAIL %s_access got valid=%b rom_addr=%h expected valid=00 rom_addr=%h", nm, rv, ra, exp_ra);
        end
        @(negedge clk);
        rv = d ? rv32 : rv64; ra = d ? {32'b0, ra32} : ra64;
        checks++;
        if (rv !== (2'b01 << p) || ra !== exp_ra) begin
            failures++;
            $display("FAIL %s_resp got valid=%b rom_addr=%h expected valid=%b rom_addr=%h", nm, rv, ra, 2'b01 << p, exp_ra);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (rdy64 !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b expected=00", rdy64); end
        checks++; if (rv64 !== 2'b00) begin failures++; $display("FAIL rst_rsp_valid got=%b expected=00", rv64); end
        checks++; if (rd64 !== 64'h0) begin failures++; $display("FAIL rst_rsp_data got=%h expected=0", rd64); end
        checks++; if (rf64 !== 2'b00) begin failures++; $display("FAIL rst_rsp_fault got=%b expected=00", rf64); end
        checks++; if (ra64 !== 64'h0) begin failures++; $display("FAIL rst_rom_addr got=%h expected=0", ra64); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back;
        int last, hit;
        bit got;
        a0 = 64'h1010; f0 = 3'b000; a1 = 64'h1014; f1 = 3'b010;
        for (int k = 0; k < 4; k++)
            sb.push_back('{1'b0, k % 2, (k % 2) ? 64'hFFFFFFFFCDAB5678 : 64'hFFFFFFFFFFFFFF80, 2'b00, "b2b"});
        v64 = 2'b11;
        @(negedge clk);
        checks++; if (rdy64 !== 2'b01) begin failures++; $display("FAIL b2b_first_tie got=%b expected=01", rdy64); end
        last = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                if (i > 0 || k > 0) @(negedge clk);
                got = |rv64;
            end
            hit = cyc;
            if (k == 3) v64 = 2'b00;
            checks++;
            if (!got || rv64 !== ((k % 2) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL b2b_grant%0d got=%b expected=%b", k, rv64, (k % 2) ? 2'b10 : 2'b01);
            end
            if (k > 0) begin
                checks++;
                if (hit - last != 3) begin failures++; $display("FAIL b2b_gap%0d got=%0d expected=3", k, hit - last); end
            end
            last = hit;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_loads;
        do_load(0, 0, 64'h1010, 3'b000, 64'hFFFFFFFFFFFFFF80, 2'b00, "lb");
        do_load(0, 0, 64'h1010, 3'b100, 64'h0000000000000080, 2'b00, "lbu");
        do_load(0, 0, 64'h1010, 3'b001, 64'hFFFFFFFFFFFFFF80, 2'b00, "lh");
        do_load(0, 0, 64'h1010, 3'b010, 64'h000000001234FF80, 2'b00, "lw");
        do_load(0, 0, 64'h1010, 3'b011, 64'hCDAB56781234FF80, 2'b00, "ld");
        do_load(0, 1, 64'h1012, 3'b101, 64'h0000000000001234, 2'b00, "lhu_p1");
        do_load(0, 0, 64'h1014, 3'b110, 64'h00000000CDAB5678, 2'b00, "lwu");
        do_load(0, 1, 64'h1016, 3'b001, 64'hFFFFFFFFFFFFCDAB, 2'b00, "lh_neg_p1");
    endtask

    task automatic test_faults;
        do_load(0, 0, 64'h1011, 3'b001, 64'h0, 2'b10, "lh_misaligned");
        do_load(0, 0, 64'h10FC, 3'b010, 64'h0, 2'b01, "lw_past_hi");
        do_load(0, 0, 64'h1010, 3'b111, 64'h0, 2'b11, "f3_illegal");
        do_load(0, 1, 64'h1011, 3'b111, 64'h0, 2'b11, "illegal_over_misaligned");
        do_load(0, 0, 64'h0FFF, 3'b000, 64'h0, 2'b01, "below_lo");
        do_load(0, 0, 64'h0FFF, 3'b001, 64'h0, 2'b10, "misaligned_over_range");
        do_load(0, 0, 64'hFFFFFFFFFFFFFFF8, 3'b011, 64'h0, 2'b01, "ld_no_wrap");
        do_load(0, 0, 64'h10F8, 3'b011, 64'h0, 2'b01, "ld_straddle_hi");
        do_load(0, 0, 64'h10FD, 3'b100, 64'h00000000000000A7, 2'b00, "lbu_at_hi");
    endtask

    task automatic test_xlen32;
        do_load(1, 0, 64'h1010, 3'b011, 64'h0, 2'b11, "x32_ld");
        do_load(1, 0, 64'h1010, 3'b010, 64'h1234FF80, 2'b00, "x32_lw");
        do_load(1, 1, 64'h1014, 3'b110, 64'h0, 2'b11, "x32_lwu");
        do_load(1, 0, 64'h1010, 3'b000, 64'hFFFFFF80, 2'b00, "x32_lb");
    endtask

    task automatic test_reset_mid;
        int hits;
        a0 = 64'h1010; f0 = 3'b000; v64 = 2'b01;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rdy64 !== 2'b01) begin failures++; $display("FAIL rmid_ready got=%b expected=01", rdy64); end
        checks++; if (rv64 !== 2'b00) begin failures++; $display("FAIL rmid_valid got=%b expected=00", rv64); end
        checks++; if (rd64 !== 64'h0) begin failures++; $display("FAIL rmid_data got=%h expected=0", rd64); end
        checks++; if (ra64 !== 64'h0) begin failures++; $display("FAIL rmid_rom_addr got=%h expected=0", ra64); end
        v64 = 2'b00;
        @(posedge clk); #1;
        v64 = 2'b01; rst = 1'b1;
        @(posedge clk); #1;
        v64 = 2'b00; rst = 1'b0;
        hits = 0;
        repeat (8) begin @(negedge clk); if (|rv64) hits++; end
        checks++; if (hits != 0) begin failures++; $display("FAIL rmid_dropped got=%0d strobes expected=0", hits); end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
        rom[8'h10] = 8'h80; rom[8'h11] = 8'hFF; rom[8'h12] = 8'h34; rom[8'h13] = 8'h12;
        rom[8'h14] = 8'h78; rom[8'h15] = 8'h56; rom[8'h16] = 8'hAB; rom[8'h17] = 8'hCD;
        test_reset;
        test_back_to_back;
        test_loads;
        test_faults;
        test_xlen32;
        test_reset_mid;
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d pending expected=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
